// File: rtl/noc_pkg.sv
// noc_pkg: definitions shared by the NoC router blocks.
//   - Output-port select encodings (3 bits). PORT_NONE makes the downstream
//     demux drive all of its outputs to zero.
//   - PORT_SEL_W: width of an output-port select.
//   - Helpers that locate the destination fields within a flit.
//     dest_y sits in the top COORD_W bits, and dest_x sits directly below it.
package noc_pkg;

  localparam int PORT_SEL_W = 3;

  localparam logic [PORT_SEL_W-1:0] PORT_LOCAL = 3'd0;
  localparam logic [PORT_SEL_W-1:0] PORT_NORTH = 3'd1;
  localparam logic [PORT_SEL_W-1:0] PORT_EAST  = 3'd2;
  localparam logic [PORT_SEL_W-1:0] PORT_SOUTH = 3'd3;
  localparam logic [PORT_SEL_W-1:0] PORT_WEST  = 3'd4;
  localparam logic [PORT_SEL_W-1:0] PORT_NONE  = 3'b111;

  // Returns the LSB index of the dest_y field.
  function automatic int dest_y_lsb(input int data_w, input int coord_w);
    return data_w - coord_w;
  endfunction

  // Returns the LSB index of the dest_x field.
  function automatic int dest_x_lsb(input int data_w, input int coord_w);
    return data_w - 2 * coord_w;
  endfunction

endpackage

// File: rtl/xy_route_calc.sv
// xy_route_calc: combinational XY (X-first) route and legality check.
// The same block is shared by all five input ports of the router.
//   dest_x, dest_y : destination coordinates taken from the flit
//   port           : output-port select (noc_pkg PORT_* encoding)
//   illegal        : the destination lies outside the MESH_X x MESH_Y mesh
module xy_route_calc
  import noc_pkg::*;
#(
  parameter int unsigned COORD_W = 2,
  parameter int unsigned MY_X    = 0,
  parameter int unsigned MY_Y    = 0,
  parameter int unsigned MESH_X  = 4,
  parameter int unsigned MESH_Y  = 4
) (
  input  logic [COORD_W-1:0]    dest_x,
  input  logic [COORD_W-1:0]    dest_y,
  output logic [PORT_SEL_W-1:0] port,
  output logic                  illegal
);

  // Widen the coordinates so that the comparisons against the 32-bit parameters
  // are done at a single width.
  logic [31:0] dx;
  logic [31:0] dy;

  assign dx = 32'(dest_x);
  assign dy = 32'(dest_y);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    port = PORT_LOCAL;
    if (dx > MY_X)      port = PORT_EAST;
    else if (dx < MY_X) port = PORT_WEST;
    else if (dy > MY_Y) port = PORT_NORTH;
    else if (dy < MY_Y) port = PORT_SOUTH;
  end

  assign illegal = (dx >= MESH_X) || (dy >= MESH_Y);

endmodule

// File: rtl/noc_input_port.sv
// noc_input_port: per-direction input stage of the NoC router.
// Incoming flits are routed on write and buffered in a DEPTH-entry FIFO. The head
// flit and its route feed the 1-to-5 output demux. Out-of-mesh flits are
// dropped, and err_drop is pulsed for them.
//   clk, rst_n : clock, synchronous active-low reset
//   in_flit    : incoming flit (dest_y in the top COORD_W bits, dest_x below it)
//   in_valid   : upstream has a flit
//   in_ready   : a flit can be accepted this cycle
//   out_flit   : head flit (0 when the FIFO is empty)
//   out_sel    : head route (PORT_NONE when the FIFO is empty)
//   out_valid  : the head is valid
//   out_ready  : downstream consumes the head this cycle
//   err_drop   : one-cycle pulse after an out-of-mesh flit is discarded
module noc_input_port
  import noc_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned COORD_W = 2,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MY_X    = 0,
  parameter int unsigned MY_Y    = 0,
  parameter int unsigned MESH_X  = 4,
  parameter int unsigned MESH_Y  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     in_flit,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_W-1:0]     out_flit,
  output logic [PORT_SEL_W-1:0] out_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  err_drop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int Y_LSB = dest_y_lsb(DATA_W, COORD_W);
  localparam int X_LSB = dest_x_lsb(DATA_W, COORD_W);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0]     flit_mem [DEPTH];
  logic [PORT_SEL_W-1:0] sel_mem  [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;

  logic [PORT_SEL_W-1:0] route;
  logic                  illegal;
  logic                  accept;
  logic                  push;
  logic                  pop;

  xy_route_calc #(
    .COORD_W (COORD_W),
    .MY_X    (MY_X),
    .MY_Y    (MY_Y),
    .MESH_X  (MESH_X),
    .MESH_Y  (MESH_Y)
  ) u_route (
    .dest_x  (in_flit[X_LSB +: COORD_W]),
    .dest_y  (in_flit[Y_LSB +: COORD_W]),
    .port    (route),
    .illegal (illegal)
  );

  assign in_ready  = rst_n && (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign accept    = in_valid && in_ready;
  // An accepted illegal flit is consumed from upstream but never stored.
  assign push      = accept && !illegal;
  assign pop       = out_valid && out_ready;

  assign out_flit  = out_valid ? flit_mem[rd_ptr] : '0;
  assign out_sel   = out_valid ? sel_mem[rd_ptr]  : PORT_NONE;

  // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      err_drop <= 1'b0;
    end else begin
      err_drop <= accept && illegal;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is not reset. count = 0 hides any stale contents, and leaving the array unreset lets it map to plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      flit_mem[wr_ptr] <= in_flit;
      sel_mem[wr_ptr]  <= route;
    end
  end

endmodule

// File: tb/tb_noc_input_port.sv
// Self-checking bench for noc_input_port (MY = (1,1), 3x3 mesh, DEPTH = 4).
// The reference is a queue of {flit, route} entries that is updated at every
// clock edge. A negedge process compares all outputs against it. The directed
// phases also pin literal values.
module tb_noc_input_port;
  import noc_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int MY_X   = 1;
  localparam int MY_Y   = 1;
  localparam int MESH_X = 3;
  localparam int MESH_Y = 3;

  typedef struct packed {
    logic [DATA_W-1:0] flit;
    logic [2:0]        sel;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] in_flit;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_flit;
  logic [2:0]        out_sel;
  logic              out_valid;
  logic              out_ready;
  logic              err_drop;

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   started  = 1'b0;
  ent_t q[$];
  bit   m_err    = 1'b0;

  noc_input_port #(
    .DATA_W(DATA_W), .COORD_W(2), .DEPTH(DEPTH), .MY_X(MY_X), .MY_Y(MY_Y),
    .MESH_X(MESH_X), .MESH_Y(MESH_Y)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_flit(in_flit), .in_valid(in_valid),
    .in_ready(in_ready), .out_flit(out_flit), .out_sel(out_sel),
    .out_valid(out_valid), .out_ready(out_ready), .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk(input int x, input int y, input int pay);
    logic [1:0] xb;
    logic [1:0] yb;
    xb = 2'(x);
    yb = 2'(y);
    return {yb, xb, 28'(pay)};
  endfunction

  // XY rule written directly from the coordinates.
  function automatic logic [2:0] ref_route(input logic [DATA_W-1:0] f);
    int x;
    int y;
    y = int'(f[31:30]);
    x = int'(f[29:28]);
    if (x != MY_X) return (x > MY_X) ? 3'd2 : 3'd4;
    if (y != MY_Y) return (y > MY_Y) ? 3'd1 : 3'd3;
    return 3'd0;
  endfunction

  function automatic bit ref_legal(input logic [DATA_W-1:0] f);
    return (int'(f[29:28]) < MESH_X) && (int'(f[31:30]) < MESH_Y);
  endfunction

  // One clock edge: advance the model with the inputs the DUT samples, then
  // move 1 time unit past the edge before new inputs are driven.
  task automatic tick();
    bit acc;
    bit pop;
    ent_t e;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      m_err = 1'b0;
    end else begin
      acc   = in_valid && (q.size() != DEPTH);
      pop   = (q.size() != 0) && out_ready;
      m_err = acc && !ref_legal(in_flit);
      if (pop) void'(q.pop_front());
      if (acc && ref_legal(in_flit)) begin
        e.flit = in_flit;
        e.sel  = ref_route(in_flit);
        q.push_back(e);
      end
    end
    started = 1'b1;
    #1;
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("in_ready",  in_ready,  rst_n && (q.size() != DEPTH));
      check("out_valid", out_valid, q.size() != 0);
      check("out_flit",  out_flit,  (q.size() != 0) ? q[0].flit : '0);
      check("out_sel",   out_sel,   (q.size() != 0) ? q[0].sel : 3'd7);
      check("err_drop",  err_drop,  m_err);
    end
  end

  int sweep_x [5] = '{1, 1, 2, 1, 0};
  int sweep_y [5] = '{1, 2, 1, 0, 1};
  logic [2:0] sweep_sel [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
  logic [DATA_W-1:0] f1;
  logic [DATA_W-1:0] f2;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_flit = '0;

    // Reset, then idle.
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_sel", out_sel, 3'd7);
    check("rst_out_flit", out_flit, 32'd0);
    check("rst_err_drop", err_drop, 1'b0);

    // Route sweep: each flit is the head for one cycle after its accept.
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_flit  = mk(sweep_x[i], sweep_y[i], 100 + i);
      tick();
      check("sweep_sel", out_sel, sweep_sel[i]);
    end
    in_valid = 1'b0;
    tick();

    // Fill and backpressure.
    out_ready = 1'b0;
    f1 = mk(0, 0, 'h111);
    f2 = mk(2, 2, 'h222);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_flit  = (i == 0) ? f1 : (i == 1) ? f2 : mk(i % 3, 2, 'h300 + i);
      tick();
      check("fill_head", out_flit, f1);
    end
    check("full_in_ready", in_ready, 1'b0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("drain_in_ready", in_ready, 1'b1);
    check("drain_head2", out_flit, f2);
    for (int i = 0; i < 4; i++) tick();

    // Concurrent push/pop at count = 2. The pointers wrap past DEPTH.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_flit = mk(i, 1, 'h400 + i); tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_flit = mk((i + 2) % 3, i % 3, 'h410 + i);
      tick();
      check("conc_count", q.size(), 2);
    end
    in_valid = 1'b0;
    tick(); tick(); tick();

    // An illegal destination is dropped without disturbing the head.
    out_ready = 1'b0;
    f1 = mk(2, 0, 'h500);
    in_valid = 1'b1; in_flit = f1; tick();
    in_flit = mk(3, 0, 'h501); tick();
    check("illegal_err", err_drop, 1'b1);
    check("illegal_head", out_flit, f1);
    in_flit = mk(0, 3, 'h502); tick();
    check("illegal_y_err", err_drop, 1'b1);
    in_valid = 1'b0; tick();
    check("illegal_err_clr", err_drop, 1'b0);

    // Reset mid-run with flits buffered.
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_flit = mk(1, i, 'h600 + i); tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0; tick();
    check("mrst_out_valid", out_valid, 1'b0);
    check("mrst_out_sel", out_sel, 3'd7);
    rst_n = 1'b1;
    f1 = mk(2, 2, 'h700);
    in_valid = 1'b1; in_flit = f1; tick();
    check("mrst_new_head", out_flit, f1);
    check("mrst_new_sel", out_sel, 3'd2);
    in_valid = 1'b0; out_ready = 1'b1; tick();

    // Random traffic, including out-of-mesh destinations.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_flit   = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) tick();
    check("final_empty", out_valid, 1'b0);

    @(negedge clk);
    started = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
